// File: rtl/ad_avg_decim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_avg_decim_pkg
// Description : Shared widths and FSM state encoding for the AD averaging
//               decimator.
// Revision    : 1.0 - initial release
// ============================================================================
package ad_avg_decim_pkg;

    localparam int AD_DATA_NBIT = 16;   // AD7606 sample width, two's complement
    localparam int AD_CHN_NUM   = 8;    // channels per conversion strobe
    localparam int AD_CHN_NBIT  = 3;    // channel select width
    localparam int MAX_LOG2N    = 6;    // largest window is 2^6 = 64 samples
    localparam int SEQ_NBIT     = 16;   // output sequence counter width

    // Window state: IDLE means no window is open
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage : ad_avg_decim_pkg
`default_nettype wire

// File: rtl/ad_chn_mux.sv
`default_nettype none
// ============================================================================
// Module      : ad_chn_mux
// Description : Picks one channel out of the packed conversion bus and
//               sign-extends it to the accumulator width. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_chn_mux #(
    parameter int DATA_NBIT = 16,
    parameter int CHN_NUM   = 8,
    parameter int CHN_NBIT  = 3,
    parameter int OUT_NBIT  = 22
) (
    input  logic [CHN_NUM*DATA_NBIT-1:0] i_data,
    input  logic [CHN_NBIT-1:0]          i_sel,
    output logic signed [OUT_NBIT-1:0]   o_sample
);

    logic [DATA_NBIT-1:0] w_chn [CHN_NUM];

    generate
        for (genvar g = 0; g < CHN_NUM; g++) begin : g_chn
            assign w_chn[g] = i_data[g*DATA_NBIT +: DATA_NBIT];
        end
    endgenerate

    // Select the requested channel; an out-of-range select yields zero
    always_comb begin
        o_sample = '0;
        for (int i = 0; i < CHN_NUM; i++) begin
            if (i_sel == CHN_NBIT'(i)) begin
                o_sample = OUT_NBIT'(signed'(w_chn[i]));
            end
        end
    end

endmodule : ad_chn_mux
`default_nettype wire

// File: rtl/ad_avg_decim.sv
`default_nettype none
// ============================================================================
// Module      : ad_avg_decim
// Description : Averaging decimator. Sums 2^n consecutive samples of one
//               selected channel and emits the floor average with a wrapping
//               sequence number, one cycle after the last sample.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_avg_decim
    import ad_avg_decim_pkg::*;
#(
    parameter int DATA_NBIT = AD_DATA_NBIT,
    parameter int CHN_NUM   = AD_CHN_NUM,
    parameter int CHN_NBIT  = AD_CHN_NBIT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CHN_NBIT-1:0]           chn_sel,
    input  logic [2:0]                    log2n,
    input  logic                          in_vd,
    input  logic [CHN_NUM*DATA_NBIT-1:0]  in_data,
    output logic                          out_vd,
    output logic [DATA_NBIT-1:0]          out_data,
    output logic [CHN_NBIT-1:0]           out_chn,
    output logic [SEQ_NBIT-1:0]           out_seq,
    output logic                          out_busy
);

    localparam int c_ACC_NBIT = DATA_NBIT + MAX_LOG2N;
    localparam int c_CNT_NBIT = MAX_LOG2N + 1;

    state_t                       r_state;
    logic [CHN_NBIT-1:0]          r_sel_q;
    logic [2:0]                   r_n_q;
    logic signed [c_ACC_NBIT-1:0] r_acc;
    logic [c_CNT_NBIT-1:0]        r_cnt;
    logic [SEQ_NBIT-1:0]          r_seq_cnt;   // index the next output will carry

    logic                         w_start;
    logic [2:0]                   w_n_req;
    logic [2:0]                   w_n;
    logic [CHN_NBIT-1:0]          w_sel;
    logic signed [c_ACC_NBIT-1:0] w_sample;
    logic signed [c_ACC_NBIT-1:0] w_sum;
    logic [c_CNT_NBIT-1:0]        w_cnt_nxt;
    logic                         w_last;

    // A strobe arriving with no window open starts one using the live selects
    assign w_start   = (r_state == ST_IDLE);
    assign w_n_req   = (log2n > 3'(MAX_LOG2N)) ? 3'(MAX_LOG2N) : log2n;
    assign w_n       = w_start ? w_n_req : r_n_q;
    assign w_sel     = w_start ? chn_sel : r_sel_q;
    assign w_sum     = w_start ? w_sample : (r_acc + w_sample);
    assign w_cnt_nxt = w_start ? c_CNT_NBIT'(1) : (r_cnt + c_CNT_NBIT'(1));
    assign w_last    = (w_cnt_nxt == (c_CNT_NBIT'(1) << w_n));

    ad_chn_mux #(
        .DATA_NBIT (DATA_NBIT),
        .CHN_NUM   (CHN_NUM),
        .CHN_NBIT  (CHN_NBIT),
        .OUT_NBIT  (c_ACC_NBIT)
    ) u_chn_mux (
        .i_data   (in_data),
        .i_sel    (w_sel),
        .o_sample (w_sample)
    );

    // Window FSM: load on start, accumulate, emit floor average on the last sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel_q   <= '0;
            r_n_q     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_seq_cnt <= '0;
            out_vd    <= 1'b0;
            out_data  <= '0;
            out_chn   <= '0;
            out_seq   <= '0;
            out_busy  <= 1'b0;
        end else begin
            out_vd <= 1'b0;
            if (!en) begin
                // Abort: drop any partial window, keep the sequence count
                r_state  <= ST_IDLE;
                r_acc    <= '0;
                r_cnt    <= '0;
                out_busy <= 1'b0;
            end else if (in_vd) begin
                if (w_start) begin
                    r_sel_q <= chn_sel;
                    r_n_q   <= w_n_req;
                end
                if (w_last) begin
                    out_vd    <= 1'b1;
                    out_data  <= DATA_NBIT'(w_sum >>> w_n);
                    out_chn   <= w_sel;
                    out_seq   <= r_seq_cnt;
                    r_seq_cnt <= r_seq_cnt + 1'b1;
                    r_state   <= ST_IDLE;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    out_busy  <= 1'b0;
                end else begin
                    r_state  <= ST_ACC;
                    r_acc    <= w_sum;
                    r_cnt    <= w_cnt_nxt;
                    out_busy <= 1'b1;
                end
            end
        end
    end

endmodule : ad_avg_decim
`default_nettype wire

// File: tb/tb_ad_avg_decim.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_avg_decim
// Description : Directed self-checking bench for ad_avg_decim.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_avg_decim;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   chn_sel;
    logic [2:0]   log2n;
    logic         in_vd;
    logic [127:0] in_data;
    logic         out_vd;
    logic [15:0]  out_data;
    logic [2:0]   out_chn;
    logic [15:0]  out_seq;
    logic         out_busy;

    int n_cmp = 0;
    int n_err = 0;
    int vd_cnt = 0;
    int vd_base;

    ad_avg_decim dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .chn_sel  (chn_sel),
        .log2n    (log2n),
        .in_vd    (in_vd),
        .in_data  (in_data),
        .out_vd   (out_vd),
        .out_data (out_data),
        .out_chn  (out_chn),
        .out_seq  (out_seq),
        .out_busy (out_busy)
    );

    always #5 clk = ~clk;

    // Selected channel gets v; the others carry distinct filler values
    function automatic logic [127:0] pack(input int sel, input logic [15:0] v);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i*16 +: 16] = (i == sel) ? v : (16'h3C3C ^ 16'(i * 16'h0101));
        end
        return d;
    endfunction

    // One clock of stimulus; outputs are observed 1 time unit after the edge
    task automatic step(input logic vd, input logic [127:0] d);
        in_vd   = vd;
        in_data = d;
        @(posedge clk);
        #1;
        if (out_vd) vd_cnt++;
        in_vd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; chn_sel = 3'd0; log2n = 3'd0;
        in_vd = 1'b0; in_data = '0;
        repeat (3) step(1'b0, '0);
        n_cmp++; if (out_vd !== 1'b0)    begin n_err++; $display("FAIL reset_vd: got %0b want 0", out_vd); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", out_data); end
        n_cmp++; if (out_chn !== 3'd0)   begin n_err++; $display("FAIL reset_chn: got %0d want 0", out_chn); end
        n_cmp++; if (out_seq !== 16'h0)  begin n_err++; $display("FAIL reset_seq: got %h want 0000", out_seq); end
        n_cmp++; if (out_busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %0b want 0", out_busy); end
        rst = 1'b0;
        step(1'b0, '0);
    endtask

    task automatic test_passthrough();
        en = 1'b1; log2n = 3'd0; chn_sel = 3'd2;
        step(1'b1, pack(2, 16'h1234));
        n_cmp++; if (out_vd !== 1'b1)      begin n_err++; $display("FAIL pass_vd: got %0b want 1", out_vd); end
        n_cmp++; if (out_data !== 16'h1234) begin n_err++; $display("FAIL pass_data: got %h want 1234", out_data); end
        n_cmp++; if (out_chn !== 3'd2)     begin n_err++; $display("FAIL pass_chn: got %0d want 2", out_chn); end
        n_cmp++; if (out_seq !== 16'd0)    begin n_err++; $display("FAIL pass_seq: got %0d want 0", out_seq); end
        step(1'b0, pack(2, 16'h5555));
        n_cmp++; if (out_vd !== 1'b0)      begin n_err++; $display("FAIL pass_vd_drop: got %0b want 0", out_vd); end
        n_cmp++; if (out_data !== 16'h1234) begin n_err++; $display("FAIL pass_hold: got %h want 1234", out_data); end
    endtask

    task automatic test_avg4();
        logic [15:0] vals [4];
        vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30; vals[3] = 16'd41;
        log2n = 3'd2; chn_sel = 3'd0;
        vd_base = vd_cnt;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pack(0, vals[i]));
            if (i == 0) begin
                n_cmp++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL avg4_busy: got %0b want 1", out_busy); end
            end
            if (i < 3) step(1'b0, pack(0, 16'hFFFF));
        end
        n_cmp++; if (out_vd !== 1'b1)     begin n_err++; $display("FAIL avg4_vd: got %0b want 1", out_vd); end
        n_cmp++; if (out_data !== 16'd25) begin n_err++; $display("FAIL avg4_data: got %0d want 25", out_data); end
        n_cmp++; if (out_chn !== 3'd0)    begin n_err++; $display("FAIL avg4_chn: got %0d want 0", out_chn); end
        n_cmp++; if (out_seq !== 16'd1)   begin n_err++; $display("FAIL avg4_seq: got %0d want 1", out_seq); end
        n_cmp++; if (out_busy !== 1'b0)   begin n_err++; $display("FAIL avg4_busy_end: got %0b want 0", out_busy); end
        n_cmp++; if (vd_cnt - vd_base !== 1) begin n_err++; $display("FAIL avg4_pulses: got %0d want 1", vd_cnt - vd_base); end
    endtask

    task automatic test_negative();
        log2n = 3'd1; chn_sel = 3'd5;
        step(1'b1, pack(5, 16'h8000));
        step(1'b1, pack(5, 16'h8001));
        n_cmp++; if (out_data !== 16'h8000) begin n_err++; $display("FAIL neg_min_data: got %h want 8000", out_data); end
        n_cmp++; if (out_seq !== 16'd2)     begin n_err++; $display("FAIL neg_min_seq: got %0d want 2", out_seq); end
        step(1'b1, pack(5, 16'hFFFF));
        step(1'b1, pack(5, 16'hFFFE));
        n_cmp++; if (out_vd !== 1'b1)       begin n_err++; $display("FAIL neg_floor_vd: got %0b want 1", out_vd); end
        n_cmp++; if (out_data !== 16'hFFFE) begin n_err++; $display("FAIL neg_floor_data: got %h want fffe", out_data); end
        n_cmp++; if (out_chn !== 3'd5)      begin n_err++; $display("FAIL neg_floor_chn: got %0d want 5", out_chn); end
    endtask

    task automatic test_back_to_back();
        log2n = 3'd6; chn_sel = 3'd7;
        vd_base = vd_cnt;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, pack(7, 16'h7FFF));
            if (i == 9) begin
                chn_sel = 3'd3;
                log2n   = 3'd7;
            end
        end
        n_cmp++; if (out_vd !== 1'b1)       begin n_err++; $display("FAIL b2b_w1_vd: got %0b want 1", out_vd); end
        n_cmp++; if (out_data !== 16'h7FFF) begin n_err++; $display("FAIL b2b_w1_data: got %h want 7fff", out_data); end
        n_cmp++; if (out_chn !== 3'd7)      begin n_err++; $display("FAIL b2b_w1_chn: got %0d want 7", out_chn); end
        n_cmp++; if (out_seq !== 16'd4)     begin n_err++; $display("FAIL b2b_w1_seq: got %0d want 4", out_seq); end
        for (int i = 0; i < 64; i++) begin
            step(1'b1, pack(3, 16'h8000));
        end
        n_cmp++; if (out_vd !== 1'b1)       begin n_err++; $display("FAIL b2b_w2_vd: got %0b want 1", out_vd); end
        n_cmp++; if (out_data !== 16'h8000) begin n_err++; $display("FAIL b2b_w2_data: got %h want 8000", out_data); end
        n_cmp++; if (out_chn !== 3'd3)      begin n_err++; $display("FAIL b2b_w2_chn: got %0d want 3", out_chn); end
        n_cmp++; if (out_seq !== 16'd5)     begin n_err++; $display("FAIL b2b_w2_seq: got %0d want 5", out_seq); end
        n_cmp++; if (vd_cnt - vd_base !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", vd_cnt - vd_base); end
    endtask

    task automatic test_abort();
        log2n = 3'd3; chn_sel = 3'd1;
        vd_base = vd_cnt;
        for (int i = 0; i < 5; i++) step(1'b1, pack(1, 16'd100));
        n_cmp++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_pre: got %0b want 1", out_busy); end
        en = 1'b0;
        step(1'b1, pack(1, 16'd100));
        n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_post: got %0b want 0", out_busy); end
        step(1'b0, '0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, pack(1, 16'd7));
        n_cmp++; if (out_vd !== 1'b1)     begin n_err++; $display("FAIL abort_vd: got %0b want 1", out_vd); end
        n_cmp++; if (out_data !== 16'd7)  begin n_err++; $display("FAIL abort_data: got %0d want 7", out_data); end
        n_cmp++; if (out_seq !== 16'd6)   begin n_err++; $display("FAIL abort_seq: got %0d want 6", out_seq); end
        n_cmp++; if (vd_cnt - vd_base !== 1) begin n_err++; $display("FAIL abort_pulses: got %0d want 1", vd_cnt - vd_base); end
    endtask

    task automatic test_seq_wrap();
        log2n = 3'd0; chn_sel = 3'd6;
        vd_base = vd_cnt;
        for (int i = 0; i < 65529; i++) step(1'b1, pack(6, 16'(i)));
        n_cmp++; if (out_seq !== 16'hFFFF)  begin n_err++; $display("FAIL wrap_top_seq: got %h want ffff", out_seq); end
        n_cmp++; if (out_data !== 16'hFFF8) begin n_err++; $display("FAIL wrap_top_data: got %h want fff8", out_data); end
        n_cmp++; if (vd_cnt - vd_base !== 65529) begin n_err++; $display("FAIL wrap_pulses: got %0d want 65529", vd_cnt - vd_base); end
        step(1'b1, pack(6, 16'hABCD));
        n_cmp++; if (out_seq !== 16'h0000)  begin n_err++; $display("FAIL wrap_seq: got %h want 0000", out_seq); end
        n_cmp++; if (out_data !== 16'hABCD) begin n_err++; $display("FAIL wrap_data: got %h want abcd", out_data); end
    endtask

    task automatic test_rst_mid();
        log2n = 3'd2; chn_sel = 3'd4;
        step(1'b1, pack(4, 16'd50));
        step(1'b1, pack(4, 16'd50));
        rst = 1'b1;
        step(1'b1, pack(4, 16'd50));
        n_cmp++; if (out_vd !== 1'b0)    begin n_err++; $display("FAIL rst_mid_vd: got %0b want 0", out_vd); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL rst_mid_data: got %h want 0000", out_data); end
        n_cmp++; if (out_chn !== 3'd0)   begin n_err++; $display("FAIL rst_mid_chn: got %0d want 0", out_chn); end
        n_cmp++; if (out_seq !== 16'h0)  begin n_err++; $display("FAIL rst_mid_seq: got %h want 0000", out_seq); end
        n_cmp++; if (out_busy !== 1'b0)  begin n_err++; $display("FAIL rst_mid_busy: got %0b want 0", out_busy); end
        rst = 1'b0;
        vd_base = vd_cnt;
        step(1'b1, pack(4, 16'd50));
        step(1'b1, pack(4, 16'd50));
        n_cmp++; if (vd_cnt - vd_base !== 0) begin n_err++; $display("FAIL rst_mid_stale: got %0d want 0", vd_cnt - vd_base); end
        step(1'b1, pack(4, 16'd50));
        step(1'b1, pack(4, 16'd54));
        n_cmp++; if (out_data !== 16'd51) begin n_err++; $display("FAIL rst_mid_data2: got %0d want 51", out_data); end
        n_cmp++; if (out_seq !== 16'd0)   begin n_err++; $display("FAIL rst_mid_seq2: got %0d want 0", out_seq); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_avg4();
        test_negative();
        test_back_to_back();
        test_abort();
        test_seq_wrap();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ad_avg_decim
`default_nettype wire
